// File: rtl/csp_merge_pkg.sv
// Shared types and constants for the csp merge/arbiter blocks.
package csp_merge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IN_ACK,
        IN_REL,
        OUT_REQ,
        OUT_REL
    } state_t;

    localparam logic SRC_Y = 1'b0;
    localparam logic SRC_Z = 1'b1;

endpackage

// File: rtl/csp_merge11_rr_arb2.sv
// Two-request round-robin arbiter; the last winner loses the next tie.
module rr_arb2
    import csp_merge_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_grant;

    // Reset to Z so that Y wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SRC_Z;
        end else if (grant_en && (|grant)) begin
            last_grant <= grant[SRC_Z];
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == SRC_Z) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/csp_merge11.sv
// Two-input four-phase merge: round-robin arbitration, one-packet buffer,
// optional source tagging of the route bit.
//
// state   | meaning
// IDLE    | waiting for y_req/z_req, captures the winner on the grant edge
// IN_ACK  | granted ack held high until the granted req falls
// IN_REL  | input released, raising x_req
// OUT_REQ | x_req high, waiting for x_ack
// OUT_REL | x_req low, waiting for x_ack to fall
module csp_merge11
    import csp_merge_pkg::*;
#(
    parameter int WIDTH   = 11,
    parameter bit TAG_SRC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y_req,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ack,
    input  logic             z_req,
    input  logic [WIDTH-1:0] z_data,
    output logic             z_ack,
    output logic             x_req,
    output logic [WIDTH-1:0] x_data,
    input  logic             x_ack
);

    state_t           state, state_next;
    logic [1:0]       grant;
    logic             grant_en;
    logic             src;
    logic             granted_req;
    logic             y_ack_next, z_ack_next, x_req_next;
    logic [WIDTH-1:0] capture;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({z_req, y_req}),
        .grant_en (grant_en),
        .grant    (grant)
    );

    assign granted_req = (src == SRC_Z) ? z_req : y_req;

    // x_data doubles as the hold register, so it is stable well before x_req.
    always_comb begin
        capture = grant[SRC_Z] ? z_data : y_data;
        if (TAG_SRC) begin
            capture[WIDTH-1] = grant[SRC_Z];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src    <= SRC_Y;
            y_ack  <= 1'b0;
            z_ack  <= 1'b0;
            x_req  <= 1'b0;
            x_data <= '0;
        end else begin
            state <= state_next;
            y_ack <= y_ack_next;
            z_ack <= z_ack_next;
            x_req <= x_req_next;
            if (grant_en) begin
                x_data <= capture;
                src    <= grant[SRC_Z];
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (|grant)      state_next = IN_ACK;
            IN_ACK:  if (!granted_req) state_next = IN_REL;
            IN_REL:                   state_next = OUT_REQ;
            OUT_REQ: if (x_ack)       state_next = OUT_REL;
            OUT_REL: if (!x_ack)      state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        y_ack_next = y_ack;
        z_ack_next = z_ack;
        x_req_next = x_req;
        grant_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    grant_en   = 1'b1;
                    y_ack_next = grant[SRC_Y];
                    z_ack_next = grant[SRC_Z];
                end
            end
            IN_ACK: begin
                if (!granted_req) begin
                    y_ack_next = 1'b0;
                    z_ack_next = 1'b0;
                end
            end
            IN_REL:  x_req_next = 1'b1;
            OUT_REQ: if (x_ack) x_req_next = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csp_merge11.sv
// Bench for csp_merge11: tagged and untagged instances share one stimulus stream.
module tb_csp_merge11;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         reset;
    logic         y_req, z_req, x_ack;
    logic [W-1:0] y_data, z_data;
    logic         y_ack, z_ack, x_req;
    logic [W-1:0] x_data;
    logic         y_ack0, z_ack0, x_req0;
    logic [W-1:0] x_data0;

    int           checks = 0;
    int           errors = 0;
    logic         pend  [2];
    logic [W-1:0] pdata [2];
    int           last_src;

    always #5 clk = ~clk;

    csp_merge11 #(.WIDTH(W), .TAG_SRC(1'b1)) dut (
        .clk(clk), .reset(reset),
        .y_req(y_req), .y_data(y_data), .y_ack(y_ack),
        .z_req(z_req), .z_data(z_data), .z_ack(z_ack),
        .x_req(x_req), .x_data(x_data), .x_ack(x_ack)
    );

    csp_merge11 #(.WIDTH(W), .TAG_SRC(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .y_req(y_req), .y_data(y_data), .y_ack(y_ack0),
        .z_req(z_req), .z_data(z_data), .z_ack(z_ack0),
        .x_req(x_req0), .x_data(x_data0), .x_ack(x_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req_on(input int ch, input logic [W-1:0] d);
        if (ch == 0) begin
            y_data = d;
            y_req  = 1'b1;
        end else begin
            z_data = d;
            z_req  = 1'b1;
        end
        pend[ch]  = 1'b1;
        pdata[ch] = d;
    endtask

    task automatic req_off(input int ch);
        if (ch == 0) y_req = 1'b0;
        else         z_req = 1'b0;
        pend[ch] = 1'b0;
    endtask

    // Serve one packet as the environment; expected winner and data come from
    // the round-robin rule applied to the bench's own record of pending requests.
    task automatic run_packet(input int xdelay, input int late_ch, input logic [W-1:0] late_d);
        int           exp_ch;
        int           got_ch;
        int           n;
        logic [W-1:0] exp_tag;
        logic [W-1:0] exp_raw;
        if (pend[0] && pend[1]) exp_ch = 1 - last_src;
        else                    exp_ch = pend[1] ? 1 : 0;
        exp_raw = pdata[exp_ch];
        exp_tag = exp_raw;
        exp_tag[W-1] = (exp_ch == 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(y_ack || z_ack) && n < 20);
        chk("ack_latency", n, 1);
        got_ch = z_ack ? 1 : 0;
        chk("grant_src", got_ch, exp_ch);
        chk("other_ack_low", (exp_ch == 1) ? y_ack : z_ack, 0);
        chk("untagged_ack", {y_ack0, z_ack0}, {y_ack, z_ack});
        last_src = exp_ch;
        req_off(exp_ch);
        tick();
        chk("ack_release", y_ack | z_ack, 0);
        chk("x_req_early", x_req, 0);
        if (late_ch >= 0) req_on(late_ch, late_d);
        tick();
        chk("x_req_rise", x_req, 1);
        chk("x_data_tag", x_data, exp_tag);
        chk("x_data_raw", x_data0, exp_raw);
        for (int i = 0; i < xdelay; i++) begin
            tick();
            chk("x_req_hold", x_req, 1);
            chk("x_data_hold", x_data, exp_tag);
            chk("wait_ack_low", y_ack | z_ack, 0);
        end
        x_ack = 1'b1;
        tick();
        chk("x_req_fall", x_req, 0);
        x_ack = 1'b0;
        tick();
        chk("idle_ack_low", y_ack | z_ack, 0);
        chk("idle_x_data", x_data, exp_tag);
    endtask

    initial begin
        int r;
        reset    = 1'b1;
        y_req    = 1'b0;
        z_req    = 1'b0;
        x_ack    = 1'b0;
        y_data   = '0;
        z_data   = '0;
        pend     = '{1'b0, 1'b0};
        pdata    = '{'0, '0};
        last_src = 1;
        repeat (3) tick();
        chk("rst_y_ack", y_ack, 0);
        chk("rst_z_ack", z_ack, 0);
        chk("rst_x_req", x_req, 0);
        chk("rst_x_data", x_data, 0);
        reset = 1'b0;
        tick();

        // single Y then single Z
        req_on(0, 11'h2A5);
        run_packet(0, -1, '0);
        req_on(1, 11'h0F0);
        run_packet(0, -1, '0);

        // both channels requesting continuously: Y, Z, Y, Z
        req_on(0, 11'h111);
        req_on(1, 11'h222);
        run_packet(0, -1, '0);
        req_on(0, 11'h333);
        run_packet(0, -1, '0);
        req_on(1, 11'h444);
        run_packet(0, -1, '0);
        run_packet(0, -1, '0);

        // slow output with a new Y request arriving mid-transfer
        req_on(0, 11'h5A5);
        run_packet(10, 0, 11'h6C3);
        run_packet(0, -1, '0);

        // randomized traffic
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(1, 3);
            if (r[0] && !pend[0]) req_on(0, W'($urandom));
            if (r[1] && !pend[1]) req_on(1, W'($urandom));
            run_packet($urandom_range(0, 3), -1, '0);
        end
        while (pend[0] || pend[1]) run_packet(0, -1, '0);

        // reset while in OUT_REQ, after Y was the last winner
        req_on(0, 11'h155);
        tick();
        chk("pre_rst_ack", y_ack, 1);
        req_off(0);
        tick();
        tick();
        chk("pre_rst_x_req", x_req, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_x_req", x_req, 0);
        chk("mid_rst_acks", {y_ack, z_ack}, 0);
        chk("mid_rst_x_data", x_data, 0);
        reset    = 1'b0;
        last_src = 1;
        req_on(0, 11'h07E);
        req_on(1, 11'h381);
        run_packet(0, -1, '0);
        run_packet(0, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
